// File: rtl/vec_mul_pipe_if.sv
// Valid/ready stream with end-of-frame marker, shared by both operand inputs and the result output.
interface vec_mul_pipe_if #(
  parameter int unsigned Width = 8
) ();
  logic [Width-1:0] data;
  logic             valid;
  logic             last;
  logic             ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/vec_mul_pipe.sv
// Two-stage elementwise signed multiplier: joins two operand streams, then rounds, shifts and
// saturates each lane product. Full valid/ready backpressure, one beat per cycle.
module vec_mul_pipe #(
  parameter int unsigned INPUT_BW    = 8,
  parameter int unsigned OUTPUT_BW   = 8,
  parameter int unsigned VECTOR_SIZE = 13,
  parameter int unsigned SHIFT       = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  vec_mul_pipe_if.slave  in1,
  vec_mul_pipe_if.slave  in2,
  vec_mul_pipe_if.master out,
  output logic           err_o
);
  localparam int unsigned PW = 2 * INPUT_BW;
  localparam int unsigned RW = PW + 1;
  localparam logic signed [RW-1:0] RoundAdd = RW'((64'd1 << SHIFT) >> 1);
  localparam logic signed [RW-1:0] MaxOut   = RW'((64'sd1 <<< (OUTPUT_BW - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MinOut   = ~MaxOut;

  logic                            s1_valid_q, s1_last_q;
  logic [VECTOR_SIZE*PW-1:0]       s1_prod_q, prod_d;
  logic                            s2_valid_q, s2_last_q;
  logic [VECTOR_SIZE*OUTPUT_BW-1:0] s2_data_q, res_d;
  logic                            err_q;
  logic                            s1_ready, s2_ready, fire;

  assign s2_ready = !s2_valid_q || out.ready;
  assign s1_ready = (!s1_valid_q || s2_ready) && !rst_i;
  // Each side is only granted when the other is present, so a beat is never half-consumed.
  assign in1.ready = s1_ready && in2.valid;
  assign in2.ready = s1_ready && in1.valid;
  assign fire      = s1_ready && in1.valid && in2.valid;

  for (genvar k = 0; k < VECTOR_SIZE; k++) begin : g_lane
    logic signed [PW-1:0]        op_a, op_b;
    logic signed [RW-1:0]        prod_ext, rnd;
    logic signed [OUTPUT_BW-1:0] sat;

    assign op_a = PW'($signed(in1.data[k*INPUT_BW +: INPUT_BW]));
    assign op_b = PW'($signed(in2.data[k*INPUT_BW +: INPUT_BW]));
    assign prod_d[k*PW +: PW] = op_a * op_b;

    // One extra bit of headroom keeps the rounding add from wrapping.
    assign prod_ext = RW'($signed(s1_prod_q[k*PW +: PW]));
    assign rnd      = (prod_ext + RoundAdd) >>> SHIFT;

    always_comb begin
      sat = rnd[OUTPUT_BW-1:0];
      if (rnd > MaxOut) begin
        sat = MaxOut[OUTPUT_BW-1:0];
      end else if (rnd < MinOut) begin
        sat = MinOut[OUTPUT_BW-1:0];
      end
    end

    assign res_d[k*OUTPUT_BW +: OUTPUT_BW] = sat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_prod_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= fire;
        if (fire) begin
          s1_prod_q <= prod_d;
          s1_last_q <= in1.last || in2.last;
        end
      end
      if (s2_ready) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= res_d;
          s2_last_q <= s1_last_q;
        end
      end
      if (fire && (in1.last != in2.last)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out.data  = s2_data_q;
  assign out.valid = s2_valid_q;
  assign out.last  = s2_last_q;
  assign err_o     = err_q;
endmodule

// File: tb/tb_vec_mul_pipe.sv
// Bench for vec_mul_pipe: two instances (SHIFT=0 and SHIFT=4) share one stimulus stream and are
// checked against an arithmetic reference model with an in-order scoreboard.
module tb_vec_mul_pipe;
  localparam int IBW = 8;
  localparam int OBW = 8;
  localparam int VS  = 13;
  localparam int IW  = IBW * VS;
  localparam int OW  = OBW * VS;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [IW-1:0] a_data, b_data;
  logic          v1, v2, l1, l2, rdy;
  logic          err0, err4;

  vec_mul_pipe_if #(.Width(IW)) a0 ();
  vec_mul_pipe_if #(.Width(IW)) b0 ();
  vec_mul_pipe_if #(.Width(OW)) y0 ();
  vec_mul_pipe_if #(.Width(IW)) a4 ();
  vec_mul_pipe_if #(.Width(IW)) b4 ();
  vec_mul_pipe_if #(.Width(OW)) y4 ();

  assign a0.data = a_data; assign a0.valid = v1; assign a0.last = l1;
  assign b0.data = b_data; assign b0.valid = v2; assign b0.last = l2;
  assign a4.data = a_data; assign a4.valid = v1; assign a4.last = l1;
  assign b4.data = b_data; assign b4.valid = v2; assign b4.last = l2;
  assign y0.ready = rdy;
  assign y4.ready = rdy;

  vec_mul_pipe #(.INPUT_BW(IBW), .OUTPUT_BW(OBW), .VECTOR_SIZE(VS), .SHIFT(0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .in1(a0), .in2(b0), .out(y0), .err_o(err0)
  );
  vec_mul_pipe #(.INPUT_BW(IBW), .OUTPUT_BW(OBW), .VECTOR_SIZE(VS), .SHIFT(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .in1(a4), .in2(b4), .out(y4), .err_o(err4)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int accept_cnt = 0;
  bit sb_on = 1'b0;

  typedef struct {
    logic [OW-1:0] d0;
    logic [OW-1:0] d4;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [IBW-1:0] a;
    logic [IBW-1:0] b;
    logic           l1;
    logic           l2;
    logic [OBW-1:0] e0;
    logic [OBW-1:0] e4;
  } vec_t;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [OW-1:0] ref_vec(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                             input int sh);
    logic [OW-1:0] res;
    logic [IBW-1:0] la, lb;
    int p, r;
    res = '0;
    for (int k = 0; k < VS; k++) begin
      la = a[k*IBW +: IBW];
      lb = b[k*IBW +: IBW];
      p = int'($signed(la)) * int'($signed(lb));
      r = (sh > 0) ? ((p + (1 << (sh - 1))) >>> sh) : p;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      res[k*OBW +: OBW] = OBW'(r);
    end
    return res;
  endfunction

  // Handshakes are stable between the drive point (posedge+1) and the next posedge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (v1 && v2 && a0.ready && b0.ready) begin
        accept_cnt++;
        if (sb_on) exp_q.push_back('{ref_vec(a_data, b_data, 0), ref_vec(a_data, b_data, 4),
                                     l1 | l2});
      end
      if (sb_on && y0.valid && rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {OW{1'b0}} | y0.valid, '0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_data0", y0.data, e.d0);
          check("sb_data4", y4.data, e.d4);
          check("sb_last", {y4.last, y0.last}, {e.last, e.last});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  vec_t vecs[10];
  logic [OW-1:0] held;
  int base, cyc;

  initial begin
    vecs[0] = '{8'd3,    8'hFB, 1'b0, 1'b0, 8'hF1, 8'hFF};  // -15 ; (-15+8)>>>4 = -1
    vecs[1] = '{8'h80,   8'h80, 1'b0, 1'b0, 8'd127, 8'd127};
    vecs[2] = '{8'h80,   8'd127, 1'b0, 1'b0, 8'h80, 8'h80};
    vecs[3] = '{8'd7,    8'd7,  1'b0, 1'b0, 8'd49, 8'd3};
    vecs[4] = '{8'hF9,   8'd7,  1'b0, 1'b0, 8'hCF, 8'hFD};  // -49 ; -3
    vecs[5] = '{8'd0,    8'd0,  1'b1, 1'b1, 8'd0,  8'd0};
    vecs[6] = '{8'd127,  8'd127, 1'b0, 1'b0, 8'd127, 8'd127};
    vecs[7] = '{8'd1,    8'hFF, 1'b0, 1'b0, 8'hFF, 8'd0};
    vecs[8] = '{8'd8,    8'd1,  1'b0, 1'b0, 8'd8,  8'd1};
    vecs[9] = '{8'hF8,   8'd1,  1'b0, 1'b0, 8'hF8, 8'd0};

    rst_i = 1'b1; a_data = '0; b_data = '0; v1 = 1'b1; v2 = 1'b1; l1 = 1'b0; l2 = 1'b0;
    rdy = 1'b1;
    step(); step();
    check("rst_valid", {OW{1'b0}} | {y4.valid, y0.valid}, '0);
    check("rst_data", y0.data | y4.data, '0);
    check("rst_last_err", {OW{1'b0}} | {y0.last, y4.last, err0, err4}, '0);
    check("rst_no_ready", {OW{1'b0}} | {a0.ready, b0.ready}, '0);
    v1 = 1'b0; v2 = 1'b0;
    rst_i = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      a_data = {VS{vecs[i].a}}; b_data = {VS{vecs[i].b}};
      l1 = vecs[i].l1; l2 = vecs[i].l2; v1 = 1'b1; v2 = 1'b1;
      step();
      v1 = 1'b0; v2 = 1'b0; l1 = 1'b0; l2 = 1'b0;
      step();
      #3;
      check($sformatf("vec%0d_valid", i), {OW{1'b0}} | {y4.valid, y0.valid}, 2'b11);
      check($sformatf("vec%0d_data0", i), y0.data, {VS{vecs[i].e0}});
      check($sformatf("vec%0d_data4", i), y4.data, {VS{vecs[i].e4}});
      check($sformatf("vec%0d_last", i), {OW{1'b0}} | y0.last, vecs[i].l1 | vecs[i].l2);
      step();
    end
    check("err_after_table", {OW{1'b0}} | {err0, err4}, '0);

    // Downstream stalled while the source keeps offering beats.
    exp_q.delete();
    sb_on = 1'b1;
    rdy = 1'b0;
    base = accept_cnt;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      a_data = {$urandom, $urandom, $urandom, $urandom};
      b_data = {$urandom, $urandom, $urandom, $urandom};
      v1 = 1'b1; v2 = 1'b1;
      if (i == 3) held = y0.data;
      step();
    end
    check("stall_accepts", OW'(accept_cnt - base), OW'(2));
    check("stall_held", y0.data, held);
    check("stall_ready_low", {OW{1'b0}} | {a0.ready, b0.ready, y0.valid}, 3'b001);
    v1 = 1'b0; v2 = 1'b0; rdy = 1'b1;
    repeat (4) step();
    check("stall_drained", OW'(exp_q.size()), '0);

    // Random jitter on both valids and ready.
    base = accept_cnt;
    cyc = 0;
    while ((accept_cnt - base) < 500 && cyc < 6000) begin
      a_data = {$urandom, $urandom, $urandom, $urandom};
      b_data = {$urandom, $urandom, $urandom, $urandom};
      v1 = ($urandom_range(3) != 0);
      v2 = ($urandom_range(3) != 0);
      rdy = ($urandom_range(3) != 0);
      l1 = ($urandom_range(7) == 0);
      l2 = l1;
      step();
      cyc++;
    end
    v1 = 1'b0; v2 = 1'b0; l1 = 1'b0; l2 = 1'b0; rdy = 1'b1;
    check("rand_beats", OW'(accept_cnt - base), OW'(500));
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    check("rand_none_lost", OW'(exp_q.size()), '0);
    check("rand_err_clear", {OW{1'b0}} | {err0, err4}, '0);

    // Mismatched last on the fourth beat.
    for (int i = 0; i < 6; i++) begin
      a_data = {$urandom, $urandom, $urandom, $urandom};
      b_data = {$urandom, $urandom, $urandom, $urandom};
      v1 = 1'b1; v2 = 1'b1; l1 = (i == 3); l2 = 1'b0;
      step();
      check($sformatf("err_beat%0d", i), {OW{1'b0}} | {err4, err0}, (i >= 3) ? 2'b11 : 2'b00);
    end
    v1 = 1'b0; v2 = 1'b0; l1 = 1'b0;
    repeat (4) step();
    check("err_drained", OW'(exp_q.size()), '0);
    check("err_sticky", {OW{1'b0}} | {err4, err0}, 2'b11);

    // Reset with the pipe full.
    rdy = 1'b0; v1 = 1'b1; v2 = 1'b1;
    repeat (3) step();
    sb_on = 1'b0;
    exp_q.delete();
    #2 rst_i = 1'b1;
    #1;
    check("midrst_valid", {OW{1'b0}} | {y4.valid, y0.valid}, '0);
    check("midrst_data", y0.data | y4.data, '0);
    check("midrst_err", {OW{1'b0}} | {err4, err0, y0.last}, '0);
    step();
    v1 = 1'b0; v2 = 1'b0; rdy = 1'b1;
    rst_i = 1'b0;
    repeat (3) step();
    check("post_rst_idle", {OW{1'b0}} | {y4.valid, y0.valid}, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
